// File: rtl/match_mon_pkg.sv
// Shared types and default widths for the match event monitor.
package match_mon_pkg;

    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_GAP_W = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_GAP_W-1:0] gap;
        logic                 first;
    } report_t;

endpackage

// File: rtl/edge_detector.sv
// Registers a flag and flags an event on its rising edge (EDGE_MODE=1) or level (EDGE_MODE=0).
module edge_detector #(
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic evt
);

    logic q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign evt = (EDGE_MODE != 0) ? (d & ~q) : d;

endmodule

// File: rtl/match_event_monitor.sv
// Timestamps sequence_detector matches and hands reports out through a one-entry valid/ready buffer.
// Optional threshold interrupt built when MATCH_IRQ_EN is defined.
module match_event_monitor
    import match_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned GAP_W      = DEF_GAP_W,
    parameter int unsigned EDGE_MODE  = 1,
    parameter int unsigned IRQ_THRESH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             clr,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic [GAP_W-1:0] rpt_gap,
    output logic             rpt_first,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow,
    output logic             irq
);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [GAP_W-1:0] gap;
        logic             first;
    } rpt_t;

    logic             evt;
    logic             act;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_inc;
    logic [CNT_W-1:0] drop_inc;
    logic             first_pending;
    logic             load;
    logic             drop;
    buf_state_t       state;
    buf_state_t       state_next;
    rpt_t             rpt_q;

    edge_detector #(
        .EDGE_MODE(EDGE_MODE)
    ) u_edge (
        .clk  (clk),
        .reset(reset),
        .d    (z),
        .evt  (evt)
    );

    // clr wins over a coincident event
    assign act = evt & ~clr;

    assign cnt_inc  = (evt_cnt  == '1) ? evt_cnt  : evt_cnt  + CNT_W'(1);
    assign gap_inc  = (gap_cnt  == '1) ? gap_cnt  : gap_cnt  + GAP_W'(1);
    assign drop_inc = (drop_cnt == '1) ? drop_cnt : drop_cnt + CNT_W'(1);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (act) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (rpt_ready) begin
                    if (act) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end else if (act) begin
                    drop = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (clr) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_q <= '0;
        end else if (clr) begin
            rpt_q <= '0;
        end else if (load) begin
            rpt_q <= '{count: cnt_inc, gap: gap_inc, first: first_pending};
        end
    end

    // counters advance on every event, accepted or dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_cnt       <= '0;
            gap_cnt       <= '0;
            first_pending <= 1'b1;
        end else if (clr) begin
            evt_cnt       <= '0;
            gap_cnt       <= '0;
            first_pending <= 1'b1;
        end else if (act) begin
            evt_cnt       <= cnt_inc;
            gap_cnt       <= '0;
            first_pending <= 1'b0;
        end else begin
            gap_cnt       <= gap_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            drop_cnt <= drop_inc;
            overflow <= 1'b1;
        end
    end

    assign rpt_valid = (state == FULL);
    assign rpt_count = rpt_q.count;
    assign rpt_gap   = rpt_q.gap;
    assign rpt_first = rpt_q.first;

`ifdef MATCH_IRQ_EN
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(IRQ_THRESH);
    localparam bit THRESH_IN_RANGE = ((IRQ_THRESH >> CNT_W) == 0);

    logic irq_hit;
    logic irq_q;

    // the counter only rises between clears, so an exact-match transition fires once
    assign irq_hit = THRESH_IN_RANGE && act && (evt_cnt != '1) && (cnt_inc == THRESH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else if (clr) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_hit;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_cfg;
    assign unused_irq_cfg = (IRQ_THRESH != 0);
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_match_event_monitor.sv
// Scoreboard bench: stimulus queues expected reports, a negedge monitor pops them on each handshake.
module tb_match_event_monitor;

    typedef struct packed {
        logic [7:0] count;
        logic [9:0] gap;
        logic       first;
    } exp_t;

`ifdef MATCH_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic clk;
    logic reset;

    logic       z_e, clr_e, rv_e, rr_e, first_e, ovf_e, irq_e;
    logic [7:0] cnt_e, drop_e;
    logic [9:0] gap_e;

    logic       z_l, clr_l, rv_l, rr_l, first_l, ovf_l, irq_l;
    logic [7:0] cnt_l, drop_l;
    logic [9:0] gap_l;

    int checks = 0;
    int errors = 0;

    exp_t sb_e[$];
    exp_t sb_l[$];

    match_event_monitor #(
        .CNT_W(8), .GAP_W(10), .EDGE_MODE(1), .IRQ_THRESH(4)
    ) dut_e (
        .clk(clk), .reset(reset), .z(z_e), .clr(clr_e),
        .rpt_valid(rv_e), .rpt_ready(rr_e), .rpt_count(cnt_e), .rpt_gap(gap_e),
        .rpt_first(first_e), .drop_cnt(drop_e), .overflow(ovf_e), .irq(irq_e)
    );

    match_event_monitor #(
        .CNT_W(8), .GAP_W(10), .EDGE_MODE(0), .IRQ_THRESH(16)
    ) dut_l (
        .clk(clk), .reset(reset), .z(z_l), .clr(clr_l),
        .rpt_valid(rv_l), .rpt_ready(rr_l), .rpt_count(cnt_l), .rpt_gap(gap_l),
        .rpt_first(first_l), .drop_cnt(drop_l), .overflow(ovf_l), .irq(irq_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_e(input int c, input int g, input bit f);
        sb_e.push_back('{count: 8'(c), gap: 10'(g), first: f});
    endtask

    task automatic push_l(input int c, input int g, input bit f);
        sb_l.push_back('{count: 8'(c), gap: 10'(g), first: f});
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            if (rv_e && rr_e) begin
                if (sb_e.size() == 0) begin
                    chk("edge_unexpected_report", {13'd0, cnt_e, gap_e, first_e}, 32'hFFFF_FFFF);
                end else begin
                    x = sb_e.pop_front();
                    chk("edge_report", {13'd0, cnt_e, gap_e, first_e}, {13'd0, x});
                end
            end
            if (rv_l && rr_l) begin
                if (sb_l.size() == 0) begin
                    chk("level_unexpected_report", {13'd0, cnt_l, gap_l, first_l}, 32'hFFFF_FFFF);
                end else begin
                    x = sb_l.pop_front();
                    chk("level_report", {13'd0, cnt_l, gap_l, first_l}, {13'd0, x});
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        z_e = 0; clr_e = 0; rr_e = 1;
        z_l = 0; clr_l = 0; rr_l = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rv_e, 0);
        chk("rst_count", cnt_e, 0);
        chk("rst_gap", gap_e, 0);
        chk("rst_first", first_e, 0);
        chk("rst_drop", drop_e, 0);
        chk("rst_ovf", ovf_e, 0);
        chk("rst_irq", irq_e, 0);
        chk("rst_valid_l", rv_l, 0);
        reset = 1'b1;

        fork
            begin : edge_branch
                // single pulse sampled on the 5th edge after reset release
                tick(4);
                z_e = 1; push_e(1, 5, 1); tick(1); z_e = 0;
                tick(1); chk("t1_valid_one_cycle", rv_e, 0);

                // 3 high, 4 low, high again
                clr_e = 1; tick(1); clr_e = 0;
                z_e = 1; push_e(1, 1, 1); tick(3);
                z_e = 0; tick(4);
                z_e = 1; push_e(2, 7, 0); tick(1); z_e = 0;

                // buffer stalled: one held report, two drops
                tick(1);
                rr_e = 0; z_e = 1; push_e(3, 2, 0); tick(1); z_e = 0;
                tick(1); z_e = 1; tick(1); z_e = 0;
                chk("stall_hold_count", cnt_e, 3);
                chk("stall_hold_gap", gap_e, 2);
                chk("stall_drop1", drop_e, 1);
                tick(1); z_e = 1; tick(1); z_e = 0;
                tick(1);
                chk("stall_valid", rv_e, 1);
                chk("stall_hold_count2", cnt_e, 3);
                chk("stall_hold_first", first_e, 0);
                chk("stall_drop2", drop_e, 2);
                chk("stall_ovf", ovf_e, 1);
                rr_e = 1; tick(1);
                chk("drain_empty", rv_e, 0);
                z_e = 1; push_e(6, 3, 0); tick(1); z_e = 0;

                // long idle saturates the gap
                tick(1100);
                z_e = 1; push_e(7, 1023, 0); tick(1); z_e = 0;
                tick(1);

                // clr on a rising edge while FULL
                rr_e = 0; z_e = 1; tick(1); z_e = 0;
                tick(1);
                chk("pre_clr_valid", rv_e, 1);
                chk("pre_clr_count", cnt_e, 8);
                chk("pre_clr_gap", gap_e, 2);
                z_e = 1; clr_e = 1; tick(1); clr_e = 0;
                chk("clr_valid", rv_e, 0);
                chk("clr_drop", drop_e, 0);
                chk("clr_ovf", ovf_e, 0);
                tick(2);
                chk("clr_held_z_no_edge", rv_e, 0);
                z_e = 0; tick(1);
                z_e = 1; rr_e = 1; push_e(1, 4, 1); tick(1); z_e = 0;
                tick(2);

                // threshold interrupt after the 4th event
                clr_e = 1; tick(1); clr_e = 0;
                for (int i = 1; i <= 5; i++) begin
                    z_e = 1; push_e(i, (i == 1) ? 1 : 2, (i == 1)); tick(1); z_e = 0;
                    chk($sformatf("irq_after_evt%0d", i), irq_e, (i == 4) ? IRQ_EXP : 1'b0);
                    tick(1);
                    chk($sformatf("irq_quiet%0d", i), irq_e, 0);
                end
            end
            begin : level_branch
                z_l = 1;
                for (int k = 1; k <= 300; k++) begin
                    push_l((k > 255) ? 255 : k, 1, (k == 1));
                end
                tick(300);
                chk("level_sat_count", cnt_l, 255);
                chk("level_valid", rv_l, 1);
                z_l = 0; tick(1);
                chk("level_empty", rv_l, 0);
                chk("level_drop", drop_l, 0);
            end
        join

        // asynchronous reset discards a pending report
        rr_e = 0; z_e = 1; tick(1); z_e = 0;
        chk("async_pre_valid", rv_e, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", rv_e, 0);
        chk("async_count", cnt_e, 0);
        chk("async_first", first_e, 0);
        chk("async_drop", drop_e, 0);
        tick(1);
        reset = 1'b1;
        tick(2);

        chk("edge_sb_drained", sb_e.size(), 0);
        chk("level_sb_drained", sb_l.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_event_monitor.md
Name: match_event_monitor

Overview:
- Downstream consumer of sequence_detector output z.
- Turns z pulses into timestamped event reports: running event count, plus cycles elapsed since the previous match.
- Reports leave through a one-entry valid/ready buffer toward a logger or CPU-visible register stage.
- Sits directly after sequence_detector in the same clock domain.

Parameters:
- CNT_W, 8, width of event counter and drop counter.
- GAP_W, 10, width of inter-event gap counter.
- EDGE_MODE, 1, 1 = count rising edges of z only; 0 = every cycle with z=1 is an event.
- IRQ_THRESH, 16, event count at which irq fires (only used with MATCH_IRQ_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- z  input  1  match flag from sequence_detector, synchronous to clk.
- clr  input  1  synchronous clear of counters, gap, sticky flags and buffer.
- rpt_valid  output  1  report buffer holds a valid report.
- rpt_ready  input  1  consumer accepts report when rpt_valid=1.
- rpt_count  output  CNT_W  event count including this event.
- rpt_gap  output  GAP_W  cycles since previous event, saturating.
- rpt_first  output  1  this is the first event since reset/clr.
- drop_cnt  output  CNT_W  events lost because buffer full, saturating.
- overflow  output  1  sticky, set on first drop.
- irq  output  1  one-cycle threshold pulse (see Optional Feature).

Behaviour:
- Reset (reset=0, async): every output and internal register goes to 0, including z_q, evt_cnt, gap_cnt, first_pending=1, buffer state EMPTY.
- Event detection:
  - z_q <= z each cycle.
  - event = z & ~z_q when EDGE_MODE=1; event = z when EDGE_MODE=0.
- Gap counter:
  - No event in a cycle: gap_cnt <= sat(gap_cnt+1).
  - Event cycle: captured gap = sat(gap_cnt+1), then gap_cnt <= 0.
  - Saturation is at 2^GAP_W-1 and holds there.
- Event counter:
  - Event cycle: evt_cnt <= sat(evt_cnt+1); the report carries the incremented value.
  - Saturation is at 2^CNT_W-1.
  - Counting continues while saturated; reports still issue.
- Report buffer, states EMPTY and FULL:
  - EMPTY & event: load {count, gap, first}, go to FULL. rpt_valid=1 in the cycle after the edge that sampled the event (latency 1).
  - FULL & rpt_ready & event: reload the new report and stay FULL (back-to-back, no bubble).
  - FULL & rpt_ready & no event: go to EMPTY, rpt_valid <= 0.
  - FULL & ~rpt_ready & event: report dropped, buffer contents unchanged; drop_cnt <= sat(drop_cnt+1); overflow <= 1. evt_cnt and gap still update, so the gap to the next accepted report spans the dropped event.
- Buffer outputs rpt_count, rpt_gap and rpt_first stay stable while rpt_valid=1 and rpt_ready=0.
- first_pending is cleared on the first event, whether that event is accepted or dropped. rpt_first = first_pending captured at load.
- clr = 1:
  - evt_cnt, gap_cnt, drop_cnt and overflow go to 0; first_pending goes to 1.
  - Buffer goes to EMPTY, rpt_valid goes to 0.
  - An event in the same cycle is ignored.
  - z_q still updates, so a z held high across clr does not generate a new edge event.
- rpt_ready while rpt_valid=0 has no effect.
- Reset asserted mid-operation takes effect immediately and asynchronously; a pending report is lost.

Optional Feature:
- Macro MATCH_IRQ_EN.
- Defined: irq pulses high for exactly one cycle, the cycle after evt_cnt transitions to IRQ_THRESH. It does not fire again until clr or reset, and it does not fire on saturation.
- Not defined: irq is tied 0 and the threshold logic is absent. The port exists in both builds.

Decomposition:
- Package match_mon_pkg:
  - buffer state enum (EMPTY, FULL);
  - default widths CNT_W and GAP_W;
  - report struct {count, gap, first}.
- One sub-module: edge_detector (registers z, outputs event per EDGE_MODE), reusable upstream for w.
- Counters and buffer stay in the top module.

Test Plan:
- Reset, then z=1 for one cycle at cycle 5, rpt_ready=1 → rpt_valid for 1 cycle with count=1, rpt_first=1.
- EDGE_MODE=1: z high for 3 cycles, low 4 cycles, high again → two reports; second has count=2, gap=7, first=0.
- rpt_ready=0 throughout, three z pulses → first report held stable, drop_cnt=2, overflow=1; then rpt_ready=1 → EMPTY next cycle.
- EDGE_MODE=0, z=1 continuously 300 cycles, rpt_ready=1, CNT_W=8 → one report per cycle, gap=1, count saturates at 255 and holds.
- No events for 1100 cycles, then one pulse → gap=1023 (saturated).
- clr asserted the same cycle as a z rising edge while FULL → rpt_valid=0 next cycle, counts 0, no report. Next pulse → count=1, first=1.
- MATCH_IRQ_EN defined, IRQ_THRESH=4, five pulses → single irq pulse the cycle after the 4th event.
